// File: rtl/sn74_pkg.sv
// Shared constants and the J/K next-state helper for the SN74 JK flip-flop bank.
package sn74_pkg;

   // Flip-flop timing family selected per bank
   localparam int MODE_PULSE = 0;   // master-slave: master on clk_n rise, slave on fall
   localparam int MODE_EDGE  = 1;   // negative-edge: acts on clk_n fall only

   // Filter counter width, enough for FILT_LEN up to 15
   localparam int CNT_W = 4;

   // Idle levels the input filters assume out of reset
   localparam logic INIT_CLK_N = 1'b1;
   localparam logic INIT_CLR_N = 1'b1;
   localparam logic INIT_PRE_N = 1'b1;
   localparam logic INIT_J     = 1'b0;
   localparam logic INIT_K     = 1'b0;

   // JK characteristic equation: 10 set, 01 reset, 11 toggle, 00 hold
   function automatic logic jk_next(input logic i_q, input logic i_j, input logic i_k);
      return (i_j & ~i_q) | (~i_k & i_q);
   endfunction

endpackage

// File: rtl/gfilt_p.sv
// Two-flop synchroniser followed by a stability counter; the filtered level only
// follows the synced input after it has differed for LEN consecutive mclk cycles.
module gfilt_p
   import sn74_pkg::*;
#(
   parameter int   LEN  = 4,
   parameter logic INIT = 1'b0
) (
   input  logic mclk,
   input  logic mrst_n,
   input  logic in,
   output logic filt,
   output logic pedge,
   output logic nedge
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LEN - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_filt;
   logic             r_pedge;
   logic             r_nedge;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise, count consecutive disagreeing cycles, update level and edge pulses
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         r_sync1 <= INIT;
         r_sync2 <= INIT;
         r_filt  <= INIT;
         r_pedge <= 1'b0;
         r_nedge <= 1'b0;
         r_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments make r_sync2 take the old r_sync1, forming a real two-stage pipeline.
         r_sync1 <= in;
         r_sync2 <= r_sync1;
         r_pedge <= 1'b0;
         r_nedge <= 1'b0;
         if (r_sync2 != r_filt) begin
            if (r_cnt == LP_LAST) begin
               r_filt  <= r_sync2;
               r_cnt   <= '0;
               r_pedge <= r_sync2;
               r_nedge <= ~r_sync2;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign filt  = r_filt;
   assign pedge = r_pedge;
   assign nedge = r_nedge;

endmodule

// File: rtl/sn74_jk_bank.sv
// Bank of WIDTH JK flip-flops emulating pulse-triggered (7473/7476/74107) or
// negative-edge (74LS73/74LS112) TTL parts, with filtered inputs and direct clear/preset.
module sn74_jk_bank
   import sn74_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MODE       = 0,
   parameter int FILT_LEN   = 4,
   parameter int SHARED_CLK = 0
) (
   input  logic             mclk,
   input  logic             mrst_n,
   input  logic [WIDTH-1:0] clk_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] clr_n,
   input  logic [WIDTH-1:0] pre_n,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);

   logic [WIDTH-1:0] w_clk_filt;
   logic [WIDTH-1:0] w_clk_pedge;
   logic [WIDTH-1:0] w_clk_nedge;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_clr_n;
   logic [WIDTH-1:0] w_pre_n;
   logic [WIDTH-1:0] w_clr_pedge;
   logic [WIDTH-1:0] w_pre_pedge;

   // Edge pulses the core never looks at
   logic [WIDTH-1:0] w_unused_j_pe;
   logic [WIDTH-1:0] w_unused_j_ne;
   logic [WIDTH-1:0] w_unused_k_pe;
   logic [WIDTH-1:0] w_unused_k_ne;
   logic [WIDTH-1:0] w_unused_clr_ne;
   logic [WIDTH-1:0] w_unused_pre_ne;

   // Clock filtering: one shared filter on clk_n[0], or one per channel
   if (SHARED_CLK != 0) begin : g_shared_clk
      logic w_clk0_filt;
      logic w_clk0_pedge;
      logic w_clk0_nedge;
      logic w_unused_clk;

      gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_CLK_N)) u_clk_filt (
         .mclk   (mclk),
         .mrst_n (mrst_n),
         .in     (clk_n[0]),
         .filt   (w_clk0_filt),
         .pedge  (w_clk0_pedge),
         .nedge  (w_clk0_nedge)
      );

      assign w_clk_filt   = {WIDTH{w_clk0_filt}};
      assign w_clk_pedge  = {WIDTH{w_clk0_pedge}};
      assign w_clk_nedge  = {WIDTH{w_clk0_nedge}};
      // Upper clock pins are deliberately ignored in shared-clock banks
      assign w_unused_clk = ^clk_n;
   end else begin : g_chan_clk
      for (genvar g = 0; g < WIDTH; g++) begin : g_clk
         gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_CLK_N)) u_clk_filt (
            .mclk   (mclk),
            .mrst_n (mrst_n),
            .in     (clk_n[g]),
            .filt   (w_clk_filt[g]),
            .pedge  (w_clk_pedge[g]),
            .nedge  (w_clk_nedge[g])
         );
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      logic r_q;
      logic r_q_n;
      logic r_q_int;
      logic w_load;
      logic w_master_next;
      logic w_edge_next;

      gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_J)) u_j_filt (
         .mclk (mclk), .mrst_n (mrst_n), .in (j[g]),
         .filt (w_j[g]), .pedge (w_unused_j_pe[g]), .nedge (w_unused_j_ne[g])
      );
      gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_K)) u_k_filt (
         .mclk (mclk), .mrst_n (mrst_n), .in (k[g]),
         .filt (w_k[g]), .pedge (w_unused_k_pe[g]), .nedge (w_unused_k_ne[g])
      );
      gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_CLR_N)) u_clr_filt (
         .mclk (mclk), .mrst_n (mrst_n), .in (clr_n[g]),
         .filt (w_clr_n[g]), .pedge (w_clr_pedge[g]), .nedge (w_unused_clr_ne[g])
      );
      gfilt_p #(.LEN(FILT_LEN), .INIT(INIT_PRE_N)) u_pre_filt (
         .mclk (mclk), .mrst_n (mrst_n), .in (pre_n[g]),
         .filt (w_pre_n[g]), .pedge (w_pre_pedge[g]), .nedge (w_unused_pre_ne[g])
      );

      // Master loads on the clock rise, or when a direct input releases while the clock is high
      assign w_load        = w_clk_pedge[g] |
                             (w_clk_filt[g] & (w_clr_pedge[g] | w_pre_pedge[g]));
      assign w_master_next = jk_next(r_q_int, w_j[g], w_k[g]);
      assign w_edge_next   = jk_next(r_q, w_j[g], w_k[g]);

      // Direct clear/preset override, then master/slave or falling-edge update
      always_ff @(posedge mclk or negedge mrst_n) begin
         if (!mrst_n) begin
            r_q_int <= 1'b0;
            r_q     <= 1'b0;
            r_q_n   <= 1'b1;
         end else if (!w_clr_n[g] && w_pre_n[g]) begin
            r_q_int <= 1'b0;
            r_q     <= 1'b0;
            r_q_n   <= 1'b1;
         end else if (w_clr_n[g] && !w_pre_n[g]) begin
            r_q_int <= 1'b1;
            r_q     <= 1'b1;
            r_q_n   <= 1'b0;
         end else if (!w_clr_n[g] && !w_pre_n[g]) begin
            // Both direct inputs low drive both TTL outputs high
            r_q_int <= 1'b0;
            r_q     <= 1'b1;
            r_q_n   <= 1'b1;
         end else if (MODE == MODE_EDGE) begin
            if (w_clk_nedge[g]) begin
               r_q_int <= w_edge_next;
               r_q     <= w_edge_next;
               r_q_n   <= ~w_edge_next;
            end
         end else begin
            if (w_load) begin
               r_q_int <= w_master_next;
            end else if (w_clk_nedge[g]) begin
               r_q     <= r_q_int;
               r_q_n   <= ~r_q_int;
            end
         end
      end

      assign q[g]   = r_q;
      assign q_n[g] = r_q_n;
   end

endmodule

// File: tb/tb_sn74_jk_bank.sv
// Self-checking bench for sn74_jk_bank: pulse-mode, edge-mode and shared-clock banks.
module tb_sn74_jk_bank;

   typedef struct {
      string      tag;
      int         unit;
      logic [7:0] q;
      logic [7:0] q_n;
   } exp_t;

   logic       mclk;
   logic       mrst_n;

   logic [3:0] p_clk_n, p_j, p_k, p_clr_n, p_pre_n, p_q, p_q_n;
   logic [3:0] e_clk_n, e_j, e_k, e_clr_n, e_pre_n, e_q, e_q_n;
   logic [7:0] s_clk_n, s_j, s_k, s_clr_n, s_pre_n, s_q, s_q_n;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         tog_cnt = 0;
   logic [7:0] s_exp1, s_exp2;

   sn74_jk_bank #(.WIDTH(4), .MODE(0), .FILT_LEN(4), .SHARED_CLK(0)) u_pulse (
      .mclk (mclk), .mrst_n (mrst_n), .clk_n (p_clk_n), .j (p_j), .k (p_k),
      .clr_n (p_clr_n), .pre_n (p_pre_n), .q (p_q), .q_n (p_q_n)
   );

   sn74_jk_bank #(.WIDTH(4), .MODE(1), .FILT_LEN(4), .SHARED_CLK(0)) u_edge (
      .mclk (mclk), .mrst_n (mrst_n), .clk_n (e_clk_n), .j (e_j), .k (e_k),
      .clr_n (e_clr_n), .pre_n (e_pre_n), .q (e_q), .q_n (e_q_n)
   );

   sn74_jk_bank #(.WIDTH(8), .MODE(0), .FILT_LEN(4), .SHARED_CLK(1)) u_shared (
      .mclk (mclk), .mrst_n (mrst_n), .clk_n (s_clk_n), .j (s_j), .k (s_k),
      .clr_n (s_clr_n), .pre_n (s_pre_n), .q (s_q), .q_n (s_q_n)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Independent reference for one bit-vector of JK flip-flops
   function automatic logic [7:0] jk_model(input logic [7:0] q, input logic [7:0] j,
                                           input logic [7:0] k);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) begin
         case ({j[b], k[b]})
            2'b10:   r[b] = 1'b1;
            2'b01:   r[b] = 1'b0;
            2'b11:   r[b] = ~q[b];
            default: r[b] = q[b];
         endcase
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   // Shared bank: ticks while the ignored clock pins keep toggling
   task automatic run_shared(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1);
         tog_cnt++;
         if (tog_cnt % 8 == 0) s_clk_n[7:1] = ~s_clk_n[7:1];
      end
   endtask

   task automatic sb_push(input string tag, input int unit, input logic [7:0] q,
                          input logic [7:0] q_n);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.q    = q;
      e.q_n  = q_n;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t       e;
      logic [7:0] oq, oqn;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      case (e.unit)
         0:       begin oq = {4'h0, p_q}; oqn = {4'h0, p_q_n}; end
         1:       begin oq = {4'h0, e_q}; oqn = {4'h0, e_q_n}; end
         default: begin oq = s_q;         oqn = s_q_n;         end
      endcase
      check({e.tag, "_q"},  oq,  e.q);
      check({e.tag, "_qn"}, oqn, e.q_n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      mrst_n  = 1'b0;
      p_clk_n = 4'hF; p_j = 4'h0; p_k = 4'h0; p_clr_n = 4'hF; p_pre_n = 4'hF;
      e_clk_n = 4'hF; e_j = 4'h0; e_k = 4'h0; e_clr_n = 4'hF; e_pre_n = 4'hF;
      s_clk_n = 8'hAB; s_j = 8'h00; s_k = 8'h00; s_clr_n = 8'hFF; s_pre_n = 8'hFF;

      // Reset state
      tick(5);
      mrst_n = 1'b1;
      sb_push("rst_pulse", 0, 8'h00, 8'h0F);
      sb_push("rst_edge",  1, 8'h00, 8'h0F);
      sb_push("rst_shared", 2, 8'h00, 8'hFF);
      tick(5);
      repeat (3) sb_check();

      // Pulse mode, J=1 K=0 on channel 0: nothing at the rise, q=1 seven cycles after the fall
      p_j = 4'b0001;
      tick(20);
      p_clk_n = 4'h0;
      sb_push("p_low", 0, 8'h00, 8'h0F);
      tick(20);
      sb_check();
      p_clk_n = 4'hF;
      sb_push("p_rise", 0, 8'h00, 8'h0F);
      tick(20);
      sb_check();
      p_clk_n = 4'h0;
      sb_push("p_fall6", 0, 8'h00, 8'h0F);
      sb_push("p_fall7", 0, 8'h01, 8'h0E);
      tick(6);
      sb_check();
      tick(1);
      sb_check();
      tick(13);

      // Toggle on channel 1 over four clock pulses, then a too-short glitch
      p_j = 4'b0010;
      p_k = 4'b0010;
      tick(20);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] exp_q;
         exp_q = (i % 2 == 0) ? 4'b0011 : 4'b0001;
         p_clk_n = 4'hF;
         tick(20);
         p_clk_n = 4'h0;
         sb_push($sformatf("p_tog%0d", i), 0, {4'h0, exp_q}, {4'h0, ~exp_q});
         tick(20);
         sb_check();
      end
      p_clk_n = 4'hF;
      tick(3);
      p_clk_n = 4'h0;
      sb_push("p_glitch", 0, 8'h01, 8'h0E);
      tick(20);
      sb_check();

      // Clear and preset together, then release-load with the clock high
      p_j = 4'b0100;
      p_k = 4'b0000;
      p_clr_n = 4'b1011;
      p_pre_n = 4'b1011;
      sb_push("p_both_low", 0, 8'h05, 8'h0E);
      tick(20);
      sb_check();
      p_clk_n = 4'hF;
      sb_push("p_both_clkhi", 0, 8'h05, 8'h0E);
      tick(20);
      sb_check();
      p_pre_n = 4'hF;
      sb_push("p_clr_only", 0, 8'h01, 8'h0E);
      tick(20);
      sb_check();
      p_clr_n = 4'hF;
      sb_push("p_clr_rel", 0, 8'h01, 8'h0E);
      tick(20);
      sb_check();
      p_clk_n = 4'h0;
      sb_push("p_rel_fall6", 0, 8'h01, 8'h0E);
      sb_push("p_rel_fall7", 0, 8'h05, 8'h0A);
      tick(6);
      sb_check();
      tick(1);
      sb_check();
      tick(13);

      // Edge mode: set/toggle at the first fall, rise ignored, J/K while high ignored
      e_j = 4'b0011;
      e_k = 4'b0010;
      tick(20);
      e_clk_n = 4'h0;
      sb_push("e_fall6", 1, 8'h00, 8'h0F);
      sb_push("e_fall7", 1, 8'h03, 8'h0C);
      tick(6);
      sb_check();
      tick(1);
      sb_check();
      tick(13);
      e_clk_n = 4'hF;
      sb_push("e_rise", 1, 8'h03, 8'h0C);
      tick(20);
      sb_check();
      e_j = 4'b0011;
      e_k = 4'b0000;
      tick(20);
      e_j = 4'b0010;
      e_k = 4'b0011;
      sb_push("e_jk_high", 1, 8'h03, 8'h0C);
      tick(20);
      sb_check();
      e_clk_n = 4'h0;
      sb_push("e_k_fall6", 1, 8'h03, 8'h0C);
      sb_push("e_k_fall7", 1, 8'h00, 8'h0F);
      tick(6);
      sb_check();
      tick(1);
      sb_check();
      tick(13);

      // Shared clock: only clk_n[0] matters, upper clock pins toggle throughout
      s_j = 8'b0011_0101;
      s_k = 8'b0101_0011;
      s_exp1 = jk_model(8'h00, s_j, s_k);
      run_shared(20);
      s_clk_n[0] = 1'b0;
      sb_push("s_low", 2, 8'h00, 8'hFF);
      run_shared(20);
      sb_check();
      s_clk_n[0] = 1'b1;
      sb_push("s_rise", 2, 8'h00, 8'hFF);
      run_shared(20);
      sb_check();
      s_clk_n[0] = 1'b0;
      sb_push("s_fall6", 2, 8'h00, 8'hFF);
      sb_push("s_fall7", 2, s_exp1, ~s_exp1);
      run_shared(6);
      sb_check();
      run_shared(1);
      sb_check();
      run_shared(13);
      s_j = 8'b1100_1010;
      s_k = 8'b1010_1100;
      s_exp2 = jk_model(s_exp1, s_j, s_k);
      run_shared(20);
      s_clk_n[0] = 1'b1;
      run_shared(20);
      s_clk_n[0] = 1'b0;
      sb_push("s_pulse2", 2, s_exp2, ~s_exp2);
      run_shared(20);
      sb_check();

      // Asynchronous reset mid-cycle while channel 0 of the pulse bank holds q=1
      sb_push("pre_rst", 0, 8'h05, 8'h0A);
      sb_check();
      #2;
      mrst_n = 1'b0;
      #1;
      sb_push("async_pulse", 0, 8'h00, 8'h0F);
      sb_push("async_shared", 2, 8'h00, 8'hFF);
      sb_check();
      sb_check();
      tick(3);
      mrst_n = 1'b1;
      sb_push("post_rst", 0, 8'h00, 8'h0F);
      tick(20);
      sb_check();

      check("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
